// File: rtl/time_pkg.sv
// Shared types, constants and field-increment helpers for the time-entry front end.
package time_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOUR,
    MIN,
    SEC
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam int HOURS_PER_DAY = 24;
  localparam int UNITS_PER_MIN = 60;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  // Hour increment with 23 -> 0 wrap.
  function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] h);
    return (h == HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : h + HOUR_W'(1);
  endfunction

  // Minute/second increment with 59 -> 0 wrap.
  function automatic logic [MIN_W-1:0] inc_unit(input logic [MIN_W-1:0] u);
    return (u == MIN_W'(UNITS_PER_MIN - 1)) ? '0 : u + MIN_W'(1);
  endfunction

endpackage

// File: rtl/time_entry_ctrl_key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter,
// accepted level and a one-cycle pulse on each accepted press (1 -> 0).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic level_d;
  logic [CNT_W-1:0] cnt;

  // Bring the raw button into the clock domain; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has been seen on every cycle of the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b1;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered edge detect on the accepted level gives the press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

// File: rtl/time_entry_ctrl.sv
// Button-driven hh:mm:ss editor: captures the live time on entry, edits a
// shadow copy field by field and commits it with a single-cycle load strobe.
module time_entry_ctrl
  import time_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int BLINK_HALF      = 12_500_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_mode_n,
  input  logic              key_next_n,
  input  logic              key_inc_n,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [MIN_W-1:0]  cur_sec,
  output logic              edit_active,
  output logic [1:0]        edit_field,
  output logic              blink,
  output logic [HOUR_W-1:0] set_hour,
  output logic [MIN_W-1:0]  set_min,
  output logic [MIN_W-1:0]  set_sec,
  output logic              load
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);

  localparam logic [RPT_W-1:0]   DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0]   PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST   = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_HALF - 1);

  state_t state;

  logic mode_press;
  logic next_press;
  logic inc_press;
  logic inc_level;
  logic mode_level_unused;
  logic next_level_unused;

  logic mode_ev;
  logic next_ev;
  logic inc_ev;
  logic rpt_fire;

  logic               rpt_armed;
  logic               rpt_started;
  logic [RPT_W-1:0]   rpt_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [BLINK_W-1:0] blink_cnt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_mode_n),
    .level (mode_level_unused),
    .press (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_next_n),
    .level (next_level_unused),
    .press (next_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_inc_n),
    .level (inc_level),
    .press (inc_press)
  );

  // Coincident presses resolve as mode > next > inc; losers are dropped.
  always_comb begin
    mode_ev  = mode_press;
    next_ev  = next_press & ~mode_press;
    inc_ev   = inc_press & ~mode_press & ~next_press;
    rpt_fire = (state != IDLE) && rpt_armed && !inc_level &&
               (rpt_cnt == (rpt_started ? PERIOD_LAST : DELAY_LAST));
  end

  // Auto-repeat timer: armed by an inc press while editing, cleared on release or field/state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_armed   <= 1'b0;
      rpt_started <= 1'b0;
      rpt_cnt     <= '0;
    end else if (state == IDLE || inc_level || mode_ev || next_ev) begin
      rpt_armed   <= 1'b0;
      rpt_started <= 1'b0;
      rpt_cnt     <= '0;
    end else if (inc_ev) begin
      rpt_armed   <= 1'b1;
      rpt_started <= 1'b0;
      rpt_cnt     <= '0;
    end else if (rpt_armed) begin
      if (rpt_fire) begin
        rpt_started <= 1'b1;
        rpt_cnt     <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
  end

  // Edit FSM with registered field decode, shadow time, blink, timeout and commit strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      edit_active <= 1'b0;
      edit_field  <= FIELD_NONE;
      blink       <= 1'b1;
      set_hour    <= '0;
      set_min     <= '0;
      set_sec     <= '0;
      load        <= 1'b0;
      idle_cnt    <= '0;
      blink_cnt   <= '0;
    end else begin
      load <= 1'b0;
      if (state == IDLE) begin
        blink     <= 1'b1;
        blink_cnt <= '0;
        idle_cnt  <= '0;
        if (mode_ev) begin
          state       <= HOUR;
          edit_active <= 1'b1;
          edit_field  <= FIELD_HOUR;
          set_hour    <= cur_hour;
          set_min     <= cur_min;
          set_sec     <= cur_sec;
        end
      end else if (mode_ev) begin
        state       <= IDLE;
        edit_active <= 1'b0;
        edit_field  <= FIELD_NONE;
        load        <= 1'b1;
        blink       <= 1'b1;
        blink_cnt   <= '0;
        idle_cnt    <= '0;
      end else if (next_ev) begin
        blink     <= 1'b1;
        blink_cnt <= '0;
        idle_cnt  <= '0;
        case (state)
          HOUR: begin
            state      <= MIN;
            edit_field <= FIELD_MIN;
          end
          MIN: begin
            state      <= SEC;
            edit_field <= FIELD_SEC;
          end
          default: begin
            state      <= HOUR;
            edit_field <= FIELD_HOUR;
          end
        endcase
      end else if (inc_ev || rpt_fire) begin
        blink     <= 1'b1;
        blink_cnt <= '0;
        idle_cnt  <= '0;
        case (state)
          HOUR:    set_hour <= inc_hour(set_hour);
          MIN:     set_min  <= inc_unit(set_min);
          default: set_sec  <= inc_unit(set_sec);
        endcase
      end else if (idle_cnt == IDLE_LAST) begin
        state       <= IDLE;
        edit_active <= 1'b0;
        edit_field  <= FIELD_NONE;
        blink       <= 1'b1;
        blink_cnt   <= '0;
        idle_cnt    <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
        if (blink_cnt == BLINK_LAST) begin
          blink     <= ~blink;
          blink_cnt <= '0;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed bench for time_entry_ctrl with short debounce/repeat/blink/timeout windows.
module tb_time_entry_ctrl;

  localparam int KEY_NONE = 0;
  localparam int KEY_MODE = 1;
  localparam int KEY_NEXT = 2;
  localparam int KEY_INC  = 3;

  typedef struct {
    int         key;
    logic [1:0] field;
    logic       active;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    int         loads;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       key_mode_n;
  logic       key_next_n;
  logic       key_inc_n;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       edit_active;
  logic [1:0] edit_field;
  logic       blink;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       load;

  int checks;
  int failures;
  int load_count;

  time_entry_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5),
    .BLINK_HALF      (8),
    .TIMEOUT_CYCLES  (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_mode_n  (key_mode_n),
    .key_next_n  (key_next_n),
    .key_inc_n   (key_inc_n),
    .cur_hour    (cur_hour),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .edit_active (edit_active),
    .edit_field  (edit_field),
    .blink       (blink),
    .set_hour    (set_hour),
    .set_min     (set_min),
    .set_sec     (set_sec),
    .load        (load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle the commit strobe is seen high.
  always @(negedge clk) begin
    if (load === 1'b1) load_count++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic driveKey(input int key, input logic value);
    case (key)
      KEY_MODE: key_mode_n = value;
      KEY_NEXT: key_next_n = value;
      KEY_INC:  key_inc_n  = value;
      default:  ;
    endcase
  endtask

  task automatic applyStimulus(input int key, input int hold);
    @(negedge clk);
    driveKey(key, 1'b0);
    repeat (hold) @(negedge clk);
    driveKey(key, 1'b1);
    repeat (12) @(negedge clk);
  endtask

  vec_t vecs[14];

  initial begin
    int loads_before;
    int found;
    int nch;
    int prev;
    int ch_val[8];
    int ch_cyc[8];

    checks     = 0;
    failures   = 0;
    load_count = 0;
    key_mode_n = 1'b1;
    key_next_n = 1'b1;
    key_inc_n  = 1'b1;
    cur_hour   = 5'd23;
    cur_min    = 6'd59;
    cur_sec    = 6'd58;
    rst_n      = 1'b0;

    vecs[0]  = '{KEY_MODE, 2'd1, 1'b1, 5'd23, 6'd59, 6'd58, 0};
    vecs[1]  = '{KEY_INC,  2'd1, 1'b1, 5'd0,  6'd59, 6'd58, 0};
    vecs[2]  = '{KEY_MODE, 2'd0, 1'b0, 5'd0,  6'd59, 6'd58, 1};
    vecs[3]  = '{KEY_MODE, 2'd1, 1'b1, 5'd23, 6'd59, 6'd58, 0};
    vecs[4]  = '{KEY_NEXT, 2'd2, 1'b1, 5'd23, 6'd59, 6'd58, 0};
    vecs[5]  = '{KEY_INC,  2'd2, 1'b1, 5'd23, 6'd0,  6'd58, 0};
    vecs[6]  = '{KEY_NEXT, 2'd3, 1'b1, 5'd23, 6'd0,  6'd58, 0};
    vecs[7]  = '{KEY_INC,  2'd3, 1'b1, 5'd23, 6'd0,  6'd59, 0};
    vecs[8]  = '{KEY_INC,  2'd3, 1'b1, 5'd23, 6'd0,  6'd0,  0};
    vecs[9]  = '{KEY_NEXT, 2'd1, 1'b1, 5'd23, 6'd0,  6'd0,  0};
    vecs[10] = '{KEY_INC,  2'd1, 1'b1, 5'd0,  6'd0,  6'd0,  0};
    vecs[11] = '{KEY_MODE, 2'd0, 1'b0, 5'd0,  6'd0,  6'd0,  1};
    vecs[12] = '{KEY_NEXT, 2'd0, 1'b0, 5'd0,  6'd0,  6'd0,  0};
    vecs[13] = '{KEY_INC,  2'd0, 1'b0, 5'd0,  6'd0,  6'd0,  0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_active", edit_active, 0);
    checkOutput("rst_field", edit_field, 0);
    checkOutput("rst_blink", blink, 1);
    checkOutput("rst_set_hour", set_hour, 0);
    checkOutput("rst_load", load, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven commit path, field walk, wraps and ignored keys in IDLE
    for (int i = 0; i < 14; i++) begin
      loads_before = load_count;
      applyStimulus(vecs[i].key, 10);
      checkOutput($sformatf("v%0d_field", i), edit_field, vecs[i].field);
      checkOutput($sformatf("v%0d_active", i), edit_active, vecs[i].active);
      checkOutput($sformatf("v%0d_hour", i), set_hour, vecs[i].hour);
      checkOutput($sformatf("v%0d_min", i), set_min, vecs[i].min);
      checkOutput($sformatf("v%0d_sec", i), set_sec, vecs[i].sec);
      checkOutput($sformatf("v%0d_loads", i), load_count - loads_before, vecs[i].loads);
    end

    // Blink: high on entry, low after 8 cycles, high again after 8 more
    @(negedge clk);
    key_mode_n = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (edit_active) found = 1;
    end
    checkOutput("entry_seen", found, 1);
    checkOutput("blink_entry", blink, 1);
    repeat (7) @(negedge clk);
    checkOutput("blink_before_toggle", blink, 1);
    @(negedge clk);
    checkOutput("blink_toggle_low", blink, 0);
    repeat (8) @(negedge clk);
    checkOutput("blink_toggle_high", blink, 1);
    key_mode_n = 1'b1;
    repeat (12) @(negedge clk);

    // Bounce rejection in HOUR, then a clean hold gives exactly one increment
    for (int i = 0; i < 3; i++) begin
      key_inc_n = 1'b0;
      repeat (3) @(negedge clk);
      key_inc_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checkOutput("bounce_hour", set_hour, 23);
    checkOutput("bounce_field", edit_field, 1);
    applyStimulus(KEY_INC, 10);
    checkOutput("clean_inc_hour", set_hour, 0);

    // Commit, re-enter at 10:58:30 and move to MIN
    loads_before = load_count;
    applyStimulus(KEY_MODE, 10);
    checkOutput("commit2_loads", load_count - loads_before, 1);
    checkOutput("commit2_hour", set_hour, 0);
    cur_hour = 5'd10;
    cur_min  = 6'd58;
    cur_sec  = 6'd30;
    applyStimulus(KEY_MODE, 10);
    applyStimulus(KEY_NEXT, 10);
    checkOutput("rpt_field", edit_field, 2);
    checkOutput("rpt_start_min", set_min, 58);

    // Auto-repeat: record each change of set_min while inc is held
    for (int i = 0; i < 8; i++) begin
      ch_val[i] = -1;
      ch_cyc[i] = -1;
    end
    nch  = 0;
    prev = int'(set_min);
    @(negedge clk);
    key_inc_n = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (int'(set_min) != prev) begin
        if (nch < 8) begin
          ch_val[nch] = int'(set_min);
          ch_cyc[nch] = i;
        end
        nch++;
        prev = int'(set_min);
        if (nch == 3) key_inc_n = 1'b1;
      end
    end
    key_inc_n = 1'b1;
    checkOutput("rpt_changes", nch, 4);
    checkOutput("rpt_val0", ch_val[0], 59);
    checkOutput("rpt_val1", ch_val[1], 0);
    checkOutput("rpt_val2", ch_val[2], 1);
    checkOutput("rpt_val3", ch_val[3], 2);
    checkOutput("rpt_delay", ch_cyc[1] - ch_cyc[0], 20);
    checkOutput("rpt_period1", ch_cyc[2] - ch_cyc[1], 5);
    checkOutput("rpt_period2", ch_cyc[3] - ch_cyc[2], 5);
    repeat (20) @(negedge clk);
    checkOutput("rpt_after_release", set_min, 2);
    checkOutput("rpt_still_min", edit_field, 2);

    // Timeout: commit, re-enter, one inc, then stay idle
    applyStimulus(KEY_MODE, 10);
    applyStimulus(KEY_MODE, 10);
    applyStimulus(KEY_INC, 10);
    checkOutput("to_inc_hour", set_hour, 11);
    loads_before = load_count;
    repeat (80) @(negedge clk);
    checkOutput("to_before_active", edit_active, 1);
    repeat (10) @(negedge clk);
    checkOutput("to_active", edit_active, 0);
    checkOutput("to_field", edit_field, 0);
    checkOutput("to_no_load", load_count - loads_before, 0);

    // Priority: mode and next pressed together in HOUR commit rather than advance
    applyStimulus(KEY_MODE, 10);
    loads_before = load_count;
    @(negedge clk);
    key_mode_n = 1'b0;
    key_next_n = 1'b0;
    repeat (10) @(negedge clk);
    key_mode_n = 1'b1;
    key_next_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("prio_field", edit_field, 0);
    checkOutput("prio_loads", load_count - loads_before, 1);

    // Field wrap SEC -> HOUR, then park in MIN
    applyStimulus(KEY_MODE, 10);
    applyStimulus(KEY_NEXT, 10);
    applyStimulus(KEY_NEXT, 10);
    checkOutput("wrap_sec_field", edit_field, 3);
    applyStimulus(KEY_NEXT, 10);
    checkOutput("wrap_hour_field", edit_field, 1);
    applyStimulus(KEY_NEXT, 10);
    checkOutput("pre_rst_field", edit_field, 2);
    checkOutput("pre_rst_hour", set_hour, 10);

    // Asynchronous reset between clock edges while editing
    loads_before = load_count;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_active", edit_active, 0);
    checkOutput("arst_field", edit_field, 0);
    checkOutput("arst_blink", blink, 1);
    checkOutput("arst_hour", set_hour, 0);
    checkOutput("arst_min", set_min, 0);
    checkOutput("arst_sec", set_sec, 0);
    checkOutput("arst_load", load, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("post_rst_field", edit_field, 0);
    checkOutput("post_rst_loads", load_count - loads_before, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
